ft600_tx_scheduler: RTL and testbench
=====================================

Name: ft600_tx_scheduler

Overview:
- Packet-level TX scheduler on the user-clock side of the FT600 245-mode bridge.
- Shares the bridge's single TX write port (tx_en/tx_in/tx_full) among NUM_CH requesters.
- Arbitrates round-robin at packet granularity and prefixes each packet with a one-word header so the host can demultiplex channels.
- Sits between channel sources (sensor/loopback/status logic) and the bridge's TX FIFO write side.

Parameters:
- NUM_CH, 4: number of requesting channels, 2..16.
- CH_BITS, 2: width of the channel index; must satisfy 2^CH_BITS >= NUM_CH.
- SYNC, 4'hA: 4-bit sync nibble placed in header bits [15:12].

Ports:
- clk  in  1  single system clock; the same clock as the bridge's user-side clk.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ch_req  in  NUM_CH  per-channel packet request, level-sensitive.
- ch_len  in  NUM_CH*8  per-channel payload length minus 1; channel i is at [8i+7:8i]; 0..255 means 1..256 words.
- ch_valid  in  NUM_CH  per-channel payload word valid.
- ch_data  in  NUM_CH*16  per-channel payload word; channel i is at [16i+15:16i].
- ch_ready  out  NUM_CH  payload word accepted this cycle; only the granted bit can be 1.
- ch_done  out  NUM_CH  one-cycle pulse after a channel's last payload word is written.
- tx_en  out  1  write strobe to the bridge TX FIFO.
- tx_in  out  16  write data to the bridge TX FIFO.
- tx_full  in  1  bridge TX FIFO full.
- busy  out  1  high in any state other than IDLE.
- grant  out  CH_BITS  index of the current or most recently granted channel.

Behaviour:
- States:
  - IDLE: no transfer in progress.
  - HEADER: header word pending.
  - PAYLOAD: payload words pending.
  - DONE: completion pulse cycle.
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0; grant=0; ch_done=0; internal word counter=0.
  - RR pointer last=NUM_CH-1, so channel 0 has highest priority after reset.
  - tx_en and ch_ready evaluate to 0 because state=IDLE.
  - Reset asserted mid-packet aborts the packet immediately. No further words are written; the partial packet stays in the bridge FIFO and the host must resync on SYNC.
- IDLE:
  - If any ch_req is 1, select the first requesting channel searching from last+1 upward with wrap modulo NUM_CH.
  - Latch grant, set last=grant, latch len=ch_len[grant], go to HEADER (one cycle of arbitration latency).
  - With no request, stay in IDLE.
- HEADER:
  - tx_in={SYNC, grant zero-extended to 4 bits, len}.
  - tx_en=~tx_full, combinational.
  - When tx_en=1 at a clk edge, go to PAYLOAD with counter=0; otherwise hold (stall).
- PAYLOAD:
  - tx_in=ch_data[grant]; ch_ready[grant]=~tx_full; tx_en=ch_valid[grant] & ~tx_full.
  - A beat occurs when tx_en=1. On a beat, the counter increments. If counter==len on that beat, go to DONE.
  - ch_valid low inserts bubbles; no timeout.
- DONE:
  - ch_done[grant]=1 for exactly one cycle; tx_en=0; return to IDLE.
  - The earliest next header write is 2 cycles after DONE.
- ch_req and ch_len are sampled only in IDLE. Deassertion or length change mid-packet is ignored, and the packet completes with the latched len.
- A requester holding ch_req through DONE is re-arbitrated, but it loses to any other requester after it in RR order (fairness).
- Only one tx_en per cycle. tx_en is never 1 while tx_full=1.
- The counter is 8 bits. A 256-word packet (len=255) must terminate on counter==255 without wrap error.
- Bytes are little-endian per the bridge; this block handles words only.

Test Plan:
- Single packet: ch1 requests with len=2 and always valid, tx_full=0. Required response:
  - Writes are 16'hA102, then 3 data words on consecutive cycles.
  - ch_done[1] pulses 1 cycle after the last word.
  - busy falls the next cycle.
- Round-robin: ch0 and ch2 request simultaneously from reset with len=0, both held. Required response:
  - Headers A000, A200, A000, A200 in that order.
  - grant toggles 0, 2, 0, 2.
- Backpressure: tx_full=1 during HEADER for 3 cycles, then asserted on alternate cycles in PAYLOAD with len=3. Required response:
  - Exactly 5 writes, in order, with no duplicates.
  - tx_en=0 whenever tx_full=1.
  - ch_ready[g] tracks ~tx_full.
- Source bubbles: ch3 len=1 with ch_valid low for 4 cycles between words. Required response:
  - Writes A301, d0, d1 with gaps.
  - ch_done[3] pulses only after d1.
- Max length: ch0 len=255. Required response: 1 header plus 256 payload words, then exactly one ch_done pulse.
- Async reset mid-PAYLOAD, asserted between clk edges after 2 of 5 words. Required response:
  - tx_en, ch_ready and busy drop immediately.
  - After release, with ch0 and ch1 both requesting, ch0 is granted first.

Source files
------------

// File: rtl/ft600_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ft600_tx_scheduler
// Brief    : Round-robin packet scheduler feeding the FT600 bridge TX FIFO;
//            each packet is prefixed with a {SYNC, channel, len} header word.
// Revision : 1.0
// ============================================================================
module ft600_tx_scheduler #(
    parameter int         NUM_CH  = 4,
    parameter int         CH_BITS = 2,
    parameter logic [3:0] SYNC    = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*8-1:0]  ch_len,
    input  logic [NUM_CH-1:0]    ch_valid,
    input  logic [NUM_CH*16-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 tx_en,
    output logic [15:0]          tx_in,
    input  logic                 tx_full,
    output logic                 busy,
    output logic [CH_BITS-1:0]   grant
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               state_q;
    logic [CH_BITS-1:0]   grant_q;
    logic [CH_BITS-1:0]   last_q;
    logic [7:0]           len_q;
    logic [7:0]           cnt_q;

    logic                 w_any;
    logic [CH_BITS-1:0]   w_pick;
    logic [CH_BITS-1:0]   w_idx;
    logic [NUM_CH-1:0]    w_gnt_oh;
    logic [15:0]          w_sel_data;
    logic                 w_sel_valid;
    logic [3:0]           w_gid;
    logic                 w_tx_en;

    // Scan from the farthest candidate toward last+1 so the nearest requester
    // after the previous grant overwrites the others and wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CH_BITS'((int'(last_q) + k) % NUM_CH);
            if (ch_req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_gnt_oh    = NUM_CH'(1) << grant_q;
    assign w_sel_data  = ch_data[int'(grant_q)*16 +: 16];
    assign w_sel_valid = ch_valid[grant_q];
    assign w_gid       = 4'(grant_q);

    always_comb begin
        w_tx_en = 1'b0;
        tx_in   = 16'h0000;
        case (state_q)
            S_HEADER: begin
                w_tx_en = ~tx_full;
                tx_in   = {SYNC, w_gid, len_q};
            end
            S_PAYLOAD: begin
                w_tx_en = w_sel_valid & ~tx_full;
                tx_in   = w_sel_data;
            end
            default: begin
                w_tx_en = 1'b0;
                tx_in   = 16'h0000;
            end
        endcase
    end

    assign tx_en    = w_tx_en;
    assign ch_ready = (state_q == S_PAYLOAD && !tx_full) ? w_gnt_oh : '0;
    assign ch_done  = (state_q == S_DONE) ? w_gnt_oh : '0;
    assign busy     = (state_q != S_IDLE);
    assign grant    = grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= CH_BITS'(NUM_CH - 1);
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        grant_q <= w_pick;
                        last_q  <= w_pick;
                        len_q   <= ch_len[int'(w_pick)*8 +: 8];
                        state_q <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_tx_en) begin
                        cnt_q   <= '0;
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // Compare before increment so len=255 ends at 255 without wrapping.
                    if (w_tx_en) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == len_q) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ft600_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft600_tx_scheduler
// Brief    : Scoreboard bench for ft600_tx_scheduler with a packet-level RR model.
// Revision : 1.0
// ============================================================================
module tb_ft600_tx_scheduler;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_req;
    logic [NCH*8-1:0]  ch_len;
    logic [NCH-1:0] ch_valid;
    logic [NCH*16-1:0] ch_data;
    logic [NCH-1:0] ch_ready;
    logic [NCH-1:0] ch_done;
    logic           tx_en;
    logic [15:0]    tx_in;
    logic           tx_full;
    logic           busy;
    logic [1:0]     grant;

    ft600_tx_scheduler #(.NUM_CH(NCH), .CH_BITS(2), .SYNC(4'hA)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_req   (ch_req),
        .ch_len   (ch_len),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .ch_done  (ch_done),
        .tx_en    (tx_en),
        .tx_in    (tx_in),
        .tx_full  (tx_full),
        .busy     (busy),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        bit          hdr;
        int          ch;
        int          len;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] sq[NCH][$];
    int          lenq[NCH][$];
    int          pend[NCH];
    int          gap[NCH];
    int          b_n[NCH];
    int          b_len[NCH][4];
    int          m_last;
    int          fmode, vmode, pat_k;
    bit          strict;
    int          errors, checks;
    int          cyc, last_wr, pay_seen;
    bit          in_pay, done_due, prev_done;
    int          cur, rem, dch;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_batch();
        for (int i = 0; i < NCH; i++) begin
            b_n[i] = 0;
            for (int j = 0; j < 4; j++) b_len[i][j] = 0;
        end
    endtask

    // Reference model: all requests appear together in IDLE and are held until
    // each channel's packets are done, so service order is plain RR from m_last.
    task automatic issue_batch();
        int   taken[NCH];
        int   left;
        int   c;
        exp_t e;
        left = 0;
        for (int i = 0; i < NCH; i++) begin
            taken[i] = 0;
            left += b_n[i];
        end
        while (left > 0) begin
            c = (m_last + 1) % NCH;
            while (taken[c] >= b_n[c]) c = (c + 1) % NCH;
            e.hdr = 1'b1;
            e.ch  = c;
            e.len = b_len[c][taken[c]];
            e.w   = {4'hA, 4'(c), 8'(e.len)};
            expq.push_back(e);
            lenq[c].push_back(e.len);
            for (int j = 0; j <= e.len; j++) begin
                e.hdr = 1'b0;
                e.w   = 16'($urandom);
                expq.push_back(e);
                sq[c].push_back(e.w);
            end
            taken[c]++;
            left--;
            m_last = c;
        end
        pat_k = 0;
        for (int i = 0; i < NCH; i++) pend[i] += b_n[i];
    endtask

    task automatic flush_model();
        expq.delete();
        for (int i = 0; i < NCH; i++) begin
            sq[i].delete();
            lenq[i].delete();
            pend[i] = 0;
            gap[i]  = 0;
        end
        in_pay = 0; done_due = 0; prev_done = 0; rem = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        bit idle;
        n = 0;
        idle = 0;
        while (!idle && n < budget) begin
            @(posedge clk); #1;
            n++;
            idle = (expq.size() == 0) && !done_due && !busy;
            for (int i = 0; i < NCH; i++) if (pend[i] != 0) idle = 0;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending words expected 0", name, expq.size());
            flush_model();
        end
    endtask

    // Source and link driver: applies inputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                ch_req[i] = (pend[i] > 0);
                ch_len[8*i +: 8]   = (lenq[i].size() > 0) ? 8'(lenq[i][0]) : 8'($urandom);
                ch_data[16*i +: 16] = (sq[i].size() > 0) ? sq[i][0] : 16'($urandom);
                if (gap[i] > 0) begin
                    ch_valid[i] = 1'b0;
                    gap[i]--;
                end else begin
                    ch_valid[i] = (sq[i].size() > 0) && (vmode != 1 || $urandom_range(0, 9) < 7);
                end
            end
            case (fmode)
                0:       tx_full = 1'b0;
                1:       tx_full = ($urandom_range(0, 9) < 3);
                default: tx_full = (pat_k >= 1 && pat_k <= 3) || (pat_k >= 4 && (pat_k % 2) == 1);
            endcase
            pat_k++;
        end
    end

    // Monitor: samples settled outputs, which describe the coming rising edge.
    initial begin
        forever begin
            @(negedge clk); #2;
            cyc++;
            check_eq("tx_en_while_full", 32'(tx_en & tx_full), 32'd0);
            check_eq("ch_done", 32'(ch_done), done_due ? 32'(1 << dch) : 32'd0);
            if (prev_done) check_eq("busy_after_done", 32'(busy), 32'd0);
            prev_done = done_due;
            if (done_due) begin
                pend[dch]--;
                if (lenq[dch].size() > 0) void'(lenq[dch].pop_front());
                done_due = 0;
            end
            check_eq("ch_ready", 32'(ch_ready), (in_pay && !tx_full) ? 32'(1 << cur) : 32'd0);
            for (int i = 0; i < NCH; i++) begin
                if (ch_ready[i] && ch_valid[i] && sq[i].size() > 0) begin
                    void'(sq[i].pop_front());
                    if (vmode == 2) gap[i] = 4;
                end
            end
            if (tx_en) begin
                if (expq.size() == 0) begin
                    check_eq("unexpected_write", 32'(tx_in), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (e.hdr) begin
                        check_eq("header", 32'(tx_in), 32'(e.w));
                        check_eq("grant", 32'(grant), 32'(e.ch));
                        in_pay = 1;
                        cur    = e.ch;
                        rem    = e.len + 1;
                    end else begin
                        check_eq("payload", 32'(tx_in), 32'(e.w));
                        if (strict) check_eq("consecutive", 32'(cyc), 32'(last_wr + 1));
                        pay_seen++;
                        rem--;
                        if (rem == 0) begin
                            in_pay   = 0;
                            done_due = 1;
                            dch      = cur;
                        end
                    end
                end
                last_wr = cyc;
            end
        end
    end

    initial begin
        int base;
        int n;
        rst = 1'b0;
        ch_req = '0; ch_len = '0; ch_valid = '0; ch_data = '0; tx_full = 1'b0;
        fmode = 0; vmode = 0; pat_k = 0; strict = 0;
        errors = 0; checks = 0; cyc = 0; last_wr = 0; pay_seen = 0;
        cur = 0; dch = 0;
        m_last = NCH - 1;
        flush_model();
        clear_batch();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_tx_en", 32'(tx_en), 32'd0);
        check_eq("rst_ch_done", 32'(ch_done), 32'd0);
        check_eq("rst_ch_ready", 32'(ch_ready), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two held requesters from reset alternate 0,2,0,2.
        clear_batch(); b_n[0] = 2; b_n[2] = 2;
        issue_batch(); wait_idle(200, "rr");

        // Single packet, no stalls: header then back-to-back payload.
        clear_batch(); b_n[1] = 1; b_len[1][0] = 2; strict = 1;
        issue_batch(); wait_idle(100, "single"); strict = 0;

        // Header stalled three cycles, then alternate full in payload.
        clear_batch(); b_n[2] = 1; b_len[2][0] = 3; fmode = 2;
        issue_batch(); wait_idle(100, "backpressure"); fmode = 0;

        // Four-cycle source bubbles between words.
        clear_batch(); b_n[3] = 1; b_len[3][0] = 1; vmode = 2;
        issue_batch(); wait_idle(100, "bubbles"); vmode = 0;

        // Maximum-length packet.
        clear_batch(); b_n[0] = 1; b_len[0][0] = 255; strict = 1;
        issue_batch(); wait_idle(600, "maxlen"); strict = 0;

        // Randomized batches with random stalls and bubbles.
        repeat (25) begin
            clear_batch();
            n = 0;
            for (int i = 0; i < NCH; i++) begin
                b_n[i] = $urandom_range(0, 2);
                n += b_n[i];
                for (int j = 0; j < 4; j++)
                    b_len[i][j] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            end
            if (n == 0) b_n[$urandom_range(0, NCH - 1)] = 1;
            fmode = $urandom_range(0, 1);
            vmode = $urandom_range(0, 1);
            issue_batch(); wait_idle(3000, "random");
        end
        fmode = 0; vmode = 0;

        // Asynchronous reset after two of five payload words.
        clear_batch(); b_n[2] = 1; b_len[2][0] = 4;
        issue_batch();
        base = pay_seen;
        n = 0;
        while (pay_seen < base + 2 && n < 50) begin
            @(negedge clk); #3;
            n++;
        end
        check_eq("reset_wait_words", 32'(pay_seen - base), 32'd2);
        @(posedge clk); #3;
        rst = 1'b0;
        flush_model();
        m_last = NCH - 1;
        #1;
        check_eq("arst_tx_en", 32'(tx_en), 32'd0);
        check_eq("arst_ch_ready", 32'(ch_ready), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_batch(); b_n[0] = 1; b_n[1] = 1; b_len[0][0] = 1; b_len[1][0] = 1;
        issue_batch(); wait_idle(100, "post_reset");

        check_eq("leftover_expected", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
